// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A + ~B + 1, one bit per clock, LSB first.
// A single full-adder cell plus a carry flip-flop; start/done handshake with borrow and overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bOut,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shiftA_r;
  logic [WIDTH-1:0] shiftB_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;

  logic             sum_s;
  logic             carryOut_s;
  logic [WIDTH-1:0] nextResult_s;
  logic             lastStep_s;
  logic             accept_s;

  function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic c);
    fullAdd = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  assign {carryOut_s, sum_s} = fullAdd(shiftA_r[0], shiftB_r[0], carry_r);
  assign nextResult_s        = {sum_s, result_r[WIDTH-1:1]};
  assign lastStep_s          = (count_r == CW'(WIDTH - 1));
  assign accept_s            = start & ((state_r == IDLE) | (state_r == DONE));

  // Control FSM, serial datapath and registered result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      shiftA_r <= '0;
      shiftB_r <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      count_r  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      D        <= '0;
      bOut     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept_s) begin
            // Subtraction as A + ~B with an initial carry of 1
            shiftA_r <= A;
            shiftB_r <= ~B;
            carry_r  <= 1'b1;
            count_r  <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          result_r <= nextResult_s;
          shiftA_r <= {1'b0, shiftA_r[WIDTH-1:1]};
          shiftB_r <= {1'b0, shiftB_r[WIDTH-1:1]};
          carry_r  <= carryOut_s;
          count_r  <= count_r + CW'(1);
          if (lastStep_s) begin
            // carry_r here is the carry into the MSB; it differs from carry-out on signed overflow
            D       <= nextResult_s;
            bOut    <= ~carryOut_s;
            ovf     <= carry_r ^ carryOut_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
